// File: rtl/joy_event_queue.sv
// Controller button conditioner: debounces the raw pressed vector, turns
// press/release edges and auto-repeat ticks into events, and queues them in a FIFO.
module joy_event_queue #(
    parameter int          DEBOUNCE_CYCLES = 21_500,
    parameter int          REPEAT_DELAY    = 8_600_000,
    parameter int          REPEAT_RATE     = 2_150_000,
    parameter logic [11:0] REPEAT_MASK     = 12'h0F0,
    parameter int          DEPTH           = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] buttons,
    output logic [11:0] held,
    output logic        ev_valid,
    output logic [5:0]  ev_data,
    input  logic        ev_ready,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW   = $clog2(RMAX + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic [3:0] lowest_set(input logic [11:0] v);
        lowest_set = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 4'(i);
            end
        end
    endfunction

    logic [11:0]   samp_r;
    logic [DW-1:0] stab_cnt_r;
    logic [11:0]   held_r;
    logic [11:0]   pending_r;
    logic          rep_active_r;
    logic          rep_first_r;
    logic [3:0]    rep_code_r;
    logic [RW-1:0] rep_cnt_r;
    logic [5:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ev_valid_r;
    logic [5:0]    ev_data_r;
    logic          overflow_r;

    logic          accept_s;
    logic          pend_any_s;
    logic [3:0]    pend_idx_s;
    logic [11:0]   pend_clr_s;
    logic          rep_due_s;
    logic          rep_set_s;
    logic          push_s;
    logic [5:0]    push_data_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [5:0]    head_nxt_s;

    assign held     = held_r;
    assign ev_valid = ev_valid_r;
    assign ev_data  = ev_data_r;
    assign overflow = overflow_r;

    // Event selection, repeat timing and FIFO bookkeeping for this cycle.
    always_comb begin
        accept_s     = (stab_cnt_r == DEB_LAST) && (samp_r != held_r);
        pend_any_s   = (pending_r != 12'd0);
        pend_idx_s   = lowest_set(pending_r);
        pend_clr_s   = 12'd0;
        rep_due_s    = rep_active_r &&
                       (rep_cnt_r == (rep_first_r ? RD_LAST : RR_LAST));
        rep_set_s    = 1'b0;
        push_s       = 1'b0;
        push_data_s  = 6'd0;
        if (pend_any_s) begin
            push_s                 = 1'b1;
            push_data_s            = {1'b0, held_r[pend_idx_s], pend_idx_s};
            pend_clr_s[pend_idx_s] = 1'b1;
            rep_set_s              = held_r[pend_idx_s] && REPEAT_MASK[pend_idx_s];
        end else if (rep_due_s) begin
            push_s      = 1'b1;
            push_data_s = {1'b1, 1'b1, rep_code_r};
        end else begin
            push_s      = 1'b0;
        end

        pop_s        = ev_valid_r && ev_ready;
        push_ok_s    = push_s && ((count_r != FULL_CNT) || pop_s);
        drop_s       = push_s && !push_ok_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_nxt_s  = count_r + CW'(push_ok_s) - CW'(pop_s);

        // An event pushed into a queue that is empty after this cycle's pop becomes the head.
        if (count_nxt_s == CW'(0)) begin
            head_nxt_s = 6'd0;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Debounce: sample, stability counter, held state and pending edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            samp_r     <= 12'd0;
            stab_cnt_r <= '0;
            held_r     <= 12'd0;
            pending_r  <= 12'd0;
        end else begin
            samp_r <= buttons;
            if (buttons != samp_r) begin
                stab_cnt_r <= '0;
            end else if (stab_cnt_r != DEB_LAST) begin
                stab_cnt_r <= stab_cnt_r + DW'(1);
            end
            if (accept_s) begin
                held_r <= samp_r;
            end
            pending_r <= (pending_r & ~pend_clr_s) |
                         (accept_s ? (samp_r ^ held_r) : 12'd0);
        end
    end

    // Auto-repeat tracker; a tick that loses to a pending event waits at its terminal count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rep_active_r <= 1'b0;
            rep_first_r  <= 1'b0;
            rep_code_r   <= 4'd0;
            rep_cnt_r    <= '0;
        end else if (rep_set_s) begin
            rep_active_r <= 1'b1;
            rep_first_r  <= 1'b1;
            rep_code_r   <= pend_idx_s;
            rep_cnt_r    <= '0;
        end else if (!held_r[rep_code_r]) begin
            rep_active_r <= 1'b0;
        end else if (rep_active_r) begin
            if (!rep_due_s) begin
                rep_cnt_r <= rep_cnt_r + RW'(1);
            end else if (!pend_any_s) begin
                rep_cnt_r   <= '0;
                rep_first_r <= 1'b0;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, registered head/valid and sticky overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ev_valid_r <= 1'b0;
            ev_data_r  <= 6'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            ev_valid_r <= (count_nxt_s != CW'(0));
            ev_data_r  <= head_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_joy_event_queue.sv
// Directed bench for joy_event_queue with short debounce/repeat timings.
module tb_joy_event_queue;

    logic        clk;
    logic        resetn;
    logic [11:0] buttons;
    logic [11:0] held;
    logic        ev_valid;
    logic [5:0]  ev_data;
    logic        ev_ready;
    logic        overflow;
    logic        ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    joy_event_queue #(
        .DEBOUNCE_CYCLES(16),
        .REPEAT_DELAY   (100),
        .REPEAT_RATE    (40),
        .REPEAT_MASK    (12'h0F0),
        .DEPTH          (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .buttons (buttons),
        .held    (held),
        .ev_valid(ev_valid),
        .ev_data (ev_data),
        .ev_ready(ev_ready),
        .overflow(overflow),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (on negedges) until ev_valid is seen, at most budget cycles.
    task automatic wait_valid(input string tag, input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (ev_valid) break;
        end
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    endtask

    // With ev_ready low: wait for an event, check it, then pop it with a one-cycle ready.
    task automatic expect_event(input string tag, input logic [5:0] exp, input int budget);
        int w;
        wait_valid(tag, budget, w);
        check({tag, "_data"}, 32'(ev_data), 32'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        int          w;
        int          seen;
        logic [5:0]  press3 [4];
        logic [5:0]  rel3   [4];
        press3 = '{6'h10, 6'h11, 6'h1A, 6'h1B};
        rel3   = '{6'h00, 6'h01, 6'h0A, 6'h0B};

        resetn   = 1'b0;
        buttons  = 12'h000;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_held", 32'(held), 32'h000);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_data", 32'(ev_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single press, exact debounce latency, then release
        buttons = 12'h001;
        repeat (16) @(negedge clk);
        check("t1_held_early", 32'(held), 32'h000);
        @(negedge clk);
        check("t1_held", 32'(held), 32'h001);
        check("t1_valid_early", 32'(ev_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(ev_valid), 32'd1);
        check("t1_data", 32'(ev_data), 32'h10);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("t1_popped", 32'(ev_valid), 32'd0);
        buttons = 12'h000;
        expect_event("t1_rel", 6'h00, 40);
        check("t1_rel_held", 32'(held), 32'h000);

        // 2: glitch shorter than the debounce window
        buttons = 12'h100;
        repeat (10) @(negedge clk);
        buttons = 12'h000;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ev_valid || (held != 12'h000)) seen = 1;
        end
        check("t2_glitch", 32'(seen), 32'd0);

        // 3: four simultaneous presses come out lowest index first on consecutive clocks
        ev_ready = 1'b1;
        buttons  = 12'hC03;
        wait_valid("t3_press", 40, w);
        check("t3_press0", 32'(ev_data), 32'(press3[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t3_press%0d_v", k), 32'(ev_valid), 32'd1);
            check($sformatf("t3_press%0d", k), 32'(ev_data), 32'(press3[k]));
        end
        @(negedge clk);
        check("t3_empty", 32'(ev_valid), 32'd0);
        buttons = 12'h000;
        wait_valid("t3_rel", 40, w);
        check("t3_rel0", 32'(ev_data), 32'(rel3[0]));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t3_rel%0d", k), 32'(ev_data), 32'(rel3[k]));
        end
        repeat (5) @(negedge clk);

        // 4: UP held -> press, first repeat after 100, then every 40; release stops it
        buttons = 12'h010;
        wait_valid("t4_press", 40, w);
        check("t4_press", 32'(ev_data), 32'h14);
        for (int r = 0; r < 4; r++) begin
            wait_valid($sformatf("t4_rep%0d", r), 150, w);
            check($sformatf("t4_rep%0d_gap", r), 32'(w), (r == 0) ? 32'd100 : 32'd40);
            check($sformatf("t4_rep%0d", r), 32'(ev_data), 32'h34);
        end
        buttons = 12'h000;
        wait_valid("t4_rel", 40, w);
        check("t4_rel", 32'(ev_data), 32'h04);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ev_valid) seen = 1;
        end
        check("t4_quiet", 32'(seen), 32'd0);
        check("t4_ovf", 32'(overflow), 32'd0);

        // 5: all buttons with consumer stalled -> 4 queued, overflow, clear, drain in order
        ev_ready = 1'b0;
        buttons  = 12'hFFF;
        repeat (40) @(negedge clk);
        check("t5_valid", 32'(ev_valid), 32'd1);
        check("t5_head", 32'(ev_data), 32'h10);
        check("t5_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            expect_event($sformatf("t5_drain%0d", k), 6'(6'h10 + k), 5);
        end
        check("t5_empty", 32'(ev_valid), 32'd0);

        // 6: release most buttons to refill the queue, then reset for one clock
        buttons = 12'h003;
        wait_valid("t6_rel", 40, w);
        check("t6_rel_head", 32'(ev_data), 32'h02);
        repeat (20) @(negedge clk);
        check("t6_ovf", 32'(overflow), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("t6_rst_valid", 32'(ev_valid), 32'd0);
        check("t6_rst_held", 32'(held), 32'h000);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        check("t6_rst_data", 32'(ev_data), 32'h00);
        expect_event("t6_again0", 6'h10, 40);
        expect_event("t6_again1", 6'h11, 5);
        check("t6_held", 32'(held), 32'h003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
